// File: rtl/fv_bank_streamer_pkg.sv
// Shared constants and types for the feature-vector bank streamer.
// The optional request queue (FVS_REQ_QUEUE_EN) uses fvs_req_t from here as well.
package fv_bank_streamer_pkg;

   localparam int Max_FV_num       = 16;
   localparam int FV_size          = 16;
   localparam int Max_Node_id      = 256;
   localparam int Num_RS2Vertex_PE = 4;
   localparam int Bank_addr_w      = 10;

   localparam int ID_W   = $clog2(Max_Node_id);
   localparam int FVN_W  = $clog2(Max_FV_num) + 1;
   localparam int BEAT_W = FVN_W - 1;
   localparam int GRP_W  = $clog2(Num_RS2Vertex_PE);

   typedef struct packed {
      logic                        sos;
      logic                        eos;
      logic [1:0][FV_size-1:0]     FV_data;
      logic [ID_W-1:0]             Node_id;
   } Bank2RS;

   typedef struct packed {
      logic [ID_W-1:0]        node_id;
      logic [Bank_addr_w-1:0] base_addr;
      logic [BEAT_W-1:0]      beats;
   } fvs_req_t;

   typedef enum logic [1:0] {IDLE, READ, WAIT_RS} fvs_state_t;

   // Element count -> bank beats: clamp to [4, Max_FV_num], odd counts round down.
   function automatic logic [BEAT_W-1:0] fv_beats(input logic [FVN_W-1:0] fv_num);
      logic [FVN_W-1:0] n;
      n = fv_num;
      if (n > FVN_W'(Max_FV_num)) n = FVN_W'(Max_FV_num);
      if (n < FVN_W'(4))          n = FVN_W'(4);
      return n[FVN_W-1:1];
   endfunction

endpackage

// File: rtl/fvs_req_fifo.sv
// Four-entry request FIFO, only built into the streamer when FVS_REQ_QUEUE_EN is defined.
module fvs_req_fifo
   import fv_bank_streamer_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  fvs_req_t push_data,
   input  logic     pop,
   output fvs_req_t head,
   output logic     empty,
   output logic     full
);

   fvs_req_t   mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(push) - 3'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == 3'd0);
   assign full  = (count == 3'd4);

endmodule

// File: rtl/fv_bank_streamer.sv
// Streams one feature vector per request from a 2-element-wide bank into the RS.
// Define FVS_REQ_QUEUE_EN to buffer up to four requests ahead of the streamer.
module fv_bank_streamer
   import fv_bank_streamer_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ID_W-1:0]        req_node_id,
   input  logic [Bank_addr_w-1:0] req_base_addr,
   input  logic [FVN_W-1:0]       req_fv_num,
   output logic                   rd_en,
   output logic [Bank_addr_w-1:0] rd_addr,
   input  logic [2*FV_size-1:0]   rd_data,
   input  logic                   unavailable,
   input  logic                   rs_empty,
   output Bank2RS                 Bank2RS_out
);

   // Handshake: a request transfers in every cycle where req_valid && req_ready.
   fvs_state_t             state;
   fvs_req_t               in_req;
   fvs_req_t               take_req;
   logic                   take;
   logic [ID_W-1:0]        node_q;
   logic [BEAT_W-1:0]      beats_q;
   logic [BEAT_W-1:0]      k_q;
   logic [GRP_W-1:0]       grp_q;
   logic                   unav_q;
   logic                   rd_en_q;
   logic                   first_q;
   logic                   last_q;
   logic [Bank_addr_w-1:0] rd_addr_q;
   logic                   beat_q;
   logic                   sos_q;
   logic                   eos_q;
   logic [ID_W-1:0]        bnode_q;

   assign in_req = '{node_id: req_node_id, base_addr: req_base_addr, beats: fv_beats(req_fv_num)};

`ifdef FVS_REQ_QUEUE_EN
   fvs_req_t fifo_head;
   logic     fifo_empty;
   logic     fifo_full;
   logic     fifo_push;
   logic     fifo_pop;
   logic     bypass;

   // An empty queue lets an IDLE request go straight through, so beat timing is unchanged.
   assign req_ready = !fifo_full && !reset;
   assign bypass    = (state == IDLE) && fifo_empty;
   assign fifo_pop  = (state == IDLE) && !fifo_empty && !reset;
   assign fifo_push = req_valid && req_ready && !bypass;
   assign take      = (state == IDLE) && !reset && (!fifo_empty || req_valid);
   assign take_req  = fifo_empty ? in_req : fifo_head;

   fvs_req_fifo u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (in_req),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );
`else
   assign req_ready = (state == IDLE) && !reset;
   assign take      = req_valid && req_ready;
   assign take_req  = in_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         node_q    <= '0;
         beats_q   <= '0;
         k_q       <= '0;
         grp_q     <= '0;
         unav_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         rd_addr_q <= '0;
         beat_q    <= 1'b0;
         sos_q     <= 1'b0;
         eos_q     <= 1'b0;
         bnode_q   <= '0;
      end else begin
         // Bank data returns one cycle after the read, so the beat tags trail rd_en by one.
         beat_q  <= rd_en_q;
         sos_q   <= rd_en_q && first_q;
         eos_q   <= rd_en_q && last_q;
         bnode_q <= rd_en_q ? node_q : '0;
         case (state)
            IDLE: begin
               if (take) begin
                  node_q    <= take_req.node_id;
                  beats_q   <= take_req.beats;
                  rd_addr_q <= take_req.base_addr;
                  rd_en_q   <= 1'b1;
                  first_q   <= 1'b1;
                  last_q    <= 1'b0;
                  k_q       <= BEAT_W'(1);
                  unav_q    <= 1'b0;
                  state     <= READ;
               end
            end
            READ: begin
               unav_q <= unav_q | unavailable;
               if (last_q) begin
                  rd_en_q <= 1'b0;
                  first_q <= 1'b0;
                  last_q  <= 1'b0;
                  grp_q   <= (grp_q == GRP_W'(Num_RS2Vertex_PE - 1)) ? '0 : grp_q + 1'b1;
                  if (unav_q || unavailable || (grp_q == GRP_W'(Num_RS2Vertex_PE - 1)))
                     state <= WAIT_RS;
                  else
                     state <= IDLE;
               end else begin
                  rd_addr_q <= rd_addr_q + 1'b1;
                  first_q   <= 1'b0;
                  last_q    <= (k_q == beats_q - 1'b1);
                  k_q       <= k_q + 1'b1;
               end
            end
            WAIT_RS: begin
               if (rs_empty) begin
                  grp_q <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_en   = rd_en_q && !reset;
   assign rd_addr = reset ? '0 : rd_addr_q;

   always_comb begin
      Bank2RS_out = '0;
      if (beat_q && !reset) begin
         Bank2RS_out.sos     = sos_q;
         Bank2RS_out.eos     = eos_q;
         Bank2RS_out.FV_data = rd_data;
         Bank2RS_out.Node_id = bnode_q;
      end
   end

endmodule

// File: tb/tb_fv_bank_streamer.sv
// Self-checking bench for fv_bank_streamer: per-cycle model compare plus directed literal checks.
module tb_fv_bank_streamer;
   import fv_bank_streamer_pkg::*;

   localparam int MAXC = 4000;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic [ID_W-1:0]        req_node_id = '0;
   logic [Bank_addr_w-1:0] req_base_addr = '0;
   logic [FVN_W-1:0]       req_fv_num = '0;
   logic                   rd_en;
   logic [Bank_addr_w-1:0] rd_addr;
   logic [2*FV_size-1:0]   rd_data = '0;
   logic                   unavailable = 1'b0;
   logic                   rs_empty = 1'b0;
   Bank2RS                 Bank2RS_out;

   fv_bank_streamer dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_node_id   (req_node_id),
      .req_base_addr (req_base_addr),
      .req_fv_num    (req_fv_num),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .unavailable   (unavailable),
      .rs_empty      (rs_empty),
      .Bank2RS_out   (Bank2RS_out)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- bank memory ----------------
   logic [31:0] mem [1024];
   logic        pend = 1'b0;
   logic [9:0]  pend_addr = '0;
   always @(posedge clk) begin
      #1;
      rd_data = pend ? mem[pend_addr] : $urandom;
   end

   // ---------------- reference model / scoreboard ----------------
   logic        e_rd_en [MAXC];
   logic [9:0]  e_rd_addr [MAXC];
   logic        e_beat [MAXC];
   logic        e_sos [MAXC];
   logic        e_eos [MAXC];
   logic [7:0]  e_node [MAXC];
   logic [31:0] exp_q [$];

   logic        a_ready [MAXC];
   logic        a_rd_en [MAXC];
   logic [9:0]  a_rd_addr [MAXC];
   logic        a_sos [MAXC];
   logic        a_eos [MAXC];
   logic [7:0]  a_node [MAXC];
   logic [31:0] a_data [MAXC];

   int m_free_at = 0;
   int m_wait_from = 0;
   int m_vs = 0;
   int m_ve = 0;
   int m_grp = 0;
   bit m_wait = 0;
   bit m_in_vec = 0;
   bit m_unav = 0;

   always @(negedge clk) begin
      int  c;
      int  n;
      int  b;
      bit  er;
      logic [31:0] ed;
      c = cyc;
      if (c < MAXC - 20) begin
         a_ready[c]   = req_ready;
         a_rd_en[c]   = rd_en;
         a_rd_addr[c] = rd_addr;
         a_sos[c]     = Bank2RS_out.sos;
         a_eos[c]     = Bank2RS_out.eos;
         a_node[c]    = Bank2RS_out.Node_id;
         a_data[c]    = Bank2RS_out.FV_data;
         pend         = rd_en;
         pend_addr    = rd_addr;
         if (reset) begin
            for (int i = c; i < c + 20; i++) begin
               e_rd_en[i] = 0; e_rd_addr[i] = 0; e_beat[i] = 0;
               e_sos[i] = 0; e_eos[i] = 0; e_node[i] = 0;
            end
            exp_q.delete();
            m_wait = 0; m_in_vec = 0; m_grp = 0; m_free_at = c + 1;
            chk("reset_outputs", 64'({req_ready, rd_en, rd_addr, Bank2RS_out}), 64'd0);
         end else begin
            er = !m_wait && (c >= m_free_at);
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("rd_en", 64'(rd_en), 64'(e_rd_en[c]));
            if (e_rd_en[c]) chk("rd_addr", 64'(rd_addr), 64'(e_rd_addr[c]));
            chk("sos", 64'(Bank2RS_out.sos), 64'(e_sos[c]));
            chk("eos", 64'(Bank2RS_out.eos), 64'(e_eos[c]));
            chk("node_id", 64'(Bank2RS_out.Node_id), 64'(e_node[c]));
            if (e_beat[c]) begin
               if (exp_q.size() == 0) begin
                  chk("fv_data_underrun", 64'd1, 64'd0);
               end else begin
                  ed = exp_q.pop_front();
                  chk("fv_data", 64'(Bank2RS_out.FV_data), 64'(ed));
               end
            end else begin
               chk("fv_data_idle", 64'(Bank2RS_out.FV_data), 64'd0);
            end
            // spec-level state: group of vectors, RS wait, unavailable seen during a vector
            if (m_wait && c >= m_wait_from && rs_empty) begin
               m_wait = 0;
               m_free_at = c + 1;
            end
            if (m_in_vec && c >= m_vs && c <= m_ve) begin
               if (unavailable) m_unav = 1;
               if (c == m_ve) begin
                  m_in_vec = 0;
                  m_grp++;
                  if (m_grp == Num_RS2Vertex_PE || m_unav) begin
                     m_wait = 1;
                     m_wait_from = c + 1;
                     m_grp = 0;
                  end
               end
            end
            if (er && req_valid) begin
               n = int'(req_fv_num);
               if (n > Max_FV_num) n = Max_FV_num;
               if (n < 4) n = 4;
               b = n / 2;
               for (int k = 0; k < b; k++) begin
                  e_rd_en[c+1+k]   = 1;
                  e_rd_addr[c+1+k] = 10'(int'(req_base_addr) + k);
                  e_beat[c+2+k]    = 1;
                  e_node[c+2+k]    = req_node_id;
                  e_sos[c+2+k]     = (k == 0);
                  e_eos[c+2+k]     = (k == b - 1);
                  exp_q.push_back(mem[10'(int'(req_base_addr) + k)]);
               end
               m_in_vec = 1; m_unav = 0;
               m_vs = c + 1; m_ve = c + b; m_free_at = c + b + 1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      req_valid = 0; unavailable = 0; rs_empty = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic send_req(input logic [7:0] id, input logic [9:0] base,
                           input logic [4:0] fvn, output int t);
      t = -1;
      req_valid = 1; req_node_id = id; req_base_addr = base; req_fv_num = fvn;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (req_ready) begin
            t = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (t < 0) begin
         checks++; errors++;
         $display("FAIL send_timeout cycle %0d: got no req_ready expected accept", cyc);
         t = 0;
      end
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, t2, p;
      int ts[4];
      bit hs;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < MAXC; i++) begin
         e_rd_en[i] = 0; e_rd_addr[i] = 0; e_beat[i] = 0;
         e_sos[i] = 0; e_eos[i] = 0; e_node[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 0;

      // single request: 8 elements at 0x10, id 5
      send_req(8'd5, 10'h10, 5'd8, t);
      repeat (8) @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         chk("s1_rd_en", 64'(a_rd_en[t+1+k]), 64'd1);
         chk("s1_rd_addr", 64'(a_rd_addr[t+1+k]), 64'(16 + k));
      end
      chk("s1_rd_done", 64'(a_rd_en[t+5]), 64'd0);
      chk("s1_sos", 64'(a_sos[t+2]), 64'd1);
      chk("s1_sos_beat1", 64'(a_sos[t+3]), 64'd0);
      chk("s1_eos_beat2", 64'(a_eos[t+4]), 64'd0);
      chk("s1_eos", 64'(a_eos[t+5]), 64'd1);
      chk("s1_node", 64'(a_node[t+3]), 64'd5);
      chk("s1_data", 64'(a_data[t+2]), 64'(mem[16]));

      // four back-to-back 16-element vectors fill a group
      do_reset();
      for (int v = 0; v < 4; v++) send_req(8'(v + 1), 10'($urandom_range(0, 1023)), 5'd16, ts[v]);
      repeat (12) @(posedge clk); #1;
      chk("s2_gap", 64'(ts[1] - ts[0]), 64'd9);
      chk("s2_eos4", 64'(a_eos[ts[3]+9]), 64'd1);
      chk("s2_wait_ready", 64'(a_ready[ts[3]+12]), 64'd0);
      p = cyc;
      rs_empty = 1;
      @(posedge clk); #1 rs_empty = 0;
      repeat (2) @(posedge clk); #1;
      chk("s2_ready_at_pulse", 64'(a_ready[p]), 64'd0);
      chk("s2_ready_after", 64'(a_ready[p+1]), 64'd1);

      // unavailable during the 2nd vector holds the 3rd request until rs_empty
      do_reset();
      send_req(8'd11, 10'h20, 5'd8, t);
      send_req(8'd12, 10'h30, 5'd8, t2);
      unavailable = 1;
      @(posedge clk); #1 unavailable = 0;
      p = 0;
      fork
         send_req(8'd13, 10'h40, 5'd8, t);
         begin
            repeat (15) @(posedge clk); #1;
            p = cyc;
            rs_empty = 1;
            @(posedge clk); #1 rs_empty = 0;
         end
      join
      repeat (8) @(posedge clk); #1;
      chk("s3_b_eos", 64'(a_eos[t2+5]), 64'd1);
      chk("s3_c_held", 64'(t), 64'(p + 1));

      // 2 and 7 elements: 2 beats and 3 beats
      do_reset();
      send_req(8'd9, 10'h40, 5'd2, t);
      repeat (5) @(posedge clk); #1;
      chk("s4a_sos", 64'(a_sos[t+2]), 64'd1);
      chk("s4a_eos_not_sos", 64'(a_eos[t+2]), 64'd0);
      chk("s4a_eos", 64'(a_eos[t+3]), 64'd1);
      send_req(8'd10, 10'h50, 5'd7, t);
      repeat (6) @(posedge clk); #1;
      chk("s4b_rd_done", 64'(a_rd_en[t+4]), 64'd0);
      chk("s4b_eos_early", 64'(a_eos[t+3]), 64'd0);
      chk("s4b_eos", 64'(a_eos[t+4]), 64'd1);

      // reset at beat 2 of 8
      do_reset();
      send_req(8'd7, 10'h100, 5'd16, t);
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      repeat (12) @(posedge clk); #1;
      chk("s5_outputs_after", 64'({a_rd_en[t+5], a_sos[t+5], a_eos[t+5], a_data[t+5], a_node[t+5]}), 64'd0);
      chk("s5_no_eos", 64'(a_eos[t+9]), 64'd0);
      send_req(8'd8, 10'h200, 5'd8, t);
      repeat (6) @(posedge clk); #1;
      chk("s5_fresh_sos", 64'(a_sos[t+2]), 64'd1);
      chk("s5_fresh_eos", 64'(a_eos[t+5]), 64'd1);

      // address wrap at the top of the bank
      do_reset();
      send_req(8'd3, 10'h3FE, 5'd8, t);
      repeat (6) @(posedge clk); #1;
      chk("s6_addr0", 64'(a_rd_addr[t+1]), 64'h3FE);
      chk("s6_addr1", 64'(a_rd_addr[t+2]), 64'h3FF);
      chk("s6_addr2", 64'(a_rd_addr[t+3]), 64'h000);
      chk("s6_addr3", 64'(a_rd_addr[t+4]), 64'h001);

      // random traffic
      do_reset();
      hs = 0;
      for (int i = 0; i < 1200; i++) begin
         if (!req_valid || hs) begin
            req_valid     = ($urandom_range(0, 2) != 0);
            req_node_id   = 8'($urandom_range(0, 255));
            req_base_addr = 10'($urandom_range(0, 1023));
            req_fv_num    = 5'($urandom_range(0, 31));
         end
         unavailable = ($urandom_range(0, 24) == 0);
         rs_empty    = ($urandom_range(0, 5) == 0);
         reset       = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         hs = req_valid && req_ready;
         @(posedge clk); #1;
      end
      req_valid = 0; unavailable = 0; rs_empty = 0; reset = 0;
      repeat (12) @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fv_bank_streamer.md
FV_BANK_STREAMER -- requirements
Module: fv_bank_streamer

Interface
REQ-001 SHALL use the shared constant Max_FV_num, default 16: maximum feature-vector elements per vector.
REQ-002 SHALL use the shared constant FV_size, default 16: bits per feature element.
REQ-003 SHALL use the shared constant Max_Node_id, default 256: node id range, with an id width of clog2(Max_Node_id).
REQ-004 SHALL use the shared constant Num_RS2Vertex_PE, default 4: number of vectors per RS group.
REQ-005 SHALL use the shared constant Bank_addr_w, default 10: bank word-address width; one bank word holds 2 elements.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk input 1 (clock); reset input 1 (synchronous, active-high).
REQ-007 SHALL have port req_valid, input, 1 bit: a stream request is offered.
REQ-008 SHALL have port req_ready, output, 1 bit: the request is accepted in the cycle where req_valid && req_ready.
REQ-009 SHALL have port req_node_id, input, clog2(Max_Node_id) bits: node id of the vector.
REQ-010 SHALL have port req_base_addr, input, Bank_addr_w bits: first bank word of the vector.
REQ-011 SHALL have port req_fv_num, input, clog2(Max_FV_num)+1 bits: element count, even, from 4 to Max_FV_num.
REQ-012 SHALL have port rd_en, output, 1 bit: bank read strobe.
REQ-013 SHALL have port rd_addr, output, Bank_addr_w bits: bank read address.
REQ-014 SHALL have port rd_data, input, 2*FV_size bits: bank read data, valid 1 cycle after rd_en.
REQ-015 SHALL have port unavailable, input, 1 bit: RS-full pulse from the receiver.
REQ-016 SHALL have port rs_empty, input, 1 bit: RS drained and able to accept a new group.
REQ-017 SHALL have port Bank2RS_out, output, Bank2RS struct: fields sos, eos, FV_data[1:0][FV_size-1:0] and Node_id.

Function
REQ-018 SHALL implement FSM states IDLE, READ and WAIT_RS.
REQ-019 SHALL drive req_ready = 1 only in IDLE and not in reset.
REQ-020 SHALL, on acceptance (state IDLE), latch node_id, base_addr and beats = req_fv_num/2, then go to READ.
REQ-021 SHALL, in READ, assert rd_en every cycle, with rd_addr = base_addr + k for beat k = 0..beats-1, and leave READ after the last beat is issued.
REQ-022 SHALL produce each beat 1 cycle after its rd_en: FV_data = rd_data, Node_id = latched id, sos = 1 on beat 0 only, eos = 1 on beat beats-1 only.
REQ-023 SHALL give a latency from acceptance at cycle t of: first rd_en at t+1, sos beat at t+2, eos beat at t+1+beats.
REQ-024 SHALL never assert sos and eos in the same cycle; sos and eos are single-cycle pulses.
REQ-025 SHALL keep beats of one vector contiguous, with no gaps and no stall mid-vector.
REQ-026 SHALL drive FV_data and Node_id to 0 in non-beat cycles.
REQ-027 SHALL count vectors issued in a group counter that wraps at Num_RS2Vertex_PE.
REQ-028 SHALL, after the eos of the Num_RS2Vertex_PE-th vector, or after any vector during which unavailable was seen high, go to WAIT_RS with req_ready = 0.
REQ-029 SHALL, in WAIT_RS, return to IDLE the cycle after rs_empty = 1 and clear the group counter.
REQ-030 SHALL clamp an odd req_fv_num down to even, and treat req_fv_num < 4 as 4.
REQ-031 SHALL clamp req_fv_num > Max_FV_num to Max_FV_num.
REQ-032 SHALL, when a new request is accepted the cycle after an eos, put the next sos ≥2 cycles after the previous eos.
REQ-033 SHALL wrap base_addr + k modulo 2^Bank_addr_w.

Reset
REQ-034 SHALL, in reset, drive sos = 0, eos = 0, FV_data = 0, Node_id = 0, rd_en = 0, rd_addr = 0 and req_ready = 0, with state IDLE and the group counter at 0.
REQ-035 SHALL, on reset mid-vector, abandon the vector (no eos emitted) and flush all queued requests.

Configuration
REQ-036 SHALL, with FVS_REQ_QUEUE_EN defined, compile in a 4-entry request FIFO: req_ready = FIFO not full regardless of state, and IDLE pops the FIFO head.
REQ-037 SHALL, with FVS_REQ_QUEUE_EN not defined, use a single holding register: req_ready only in IDLE.
REQ-038 SHALL keep the beat timing of REQ-021 to REQ-033 identical with and without FVS_REQ_QUEUE_EN.

Structure
REQ-039 SHALL place the Bank2RS struct and the constants Max_FV_num, FV_size, Max_Node_id, Num_RS2Vertex_PE and Bank_addr_w in the shared package.
REQ-040 SHALL implement the FIFO as sub-module fvs_req_fifo, instantiated only under FVS_REQ_QUEUE_EN.

Verification
REQ-041 SHALL cover a single request (fv_num = 8, base = 0x10, id = 5): rd_addr 0x10..0x13, 4 beats, sos at beat 0, eos at beat 3, Node_id = 5.
REQ-042 SHALL cover four back-to-back fv_num = 16 requests: 8 beats each, WAIT_RS after the 4th eos, req_ready = 0 until rs_empty is pulsed, then IDLE.
REQ-043 SHALL cover an unavailable pulse during the 2nd vector: that vector completes fully, then WAIT_RS, and the 3rd request is held until rs_empty.
REQ-044 SHALL cover fv_num = 2 and fv_num = 7: 2 beats and 3 beats respectively, with sos and eos never coincident.
REQ-045 SHALL cover reset asserted at beat 2 of 8: the next cycle has all outputs 0, no eos, and a fresh request streams normally.
REQ-046 SHALL cover base = 2^Bank_addr_w-2 with fv_num = 8: rd_addr sequence wraps as ...FE, ...FF, 0, 1.
